// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// Round-robin on contention; one op in flight: IDLE -> EXEC -> RESP.
module alu_arbiter #(
  parameter int NB_OP   = 6,
  parameter int NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0_valid,
  input  logic [NB_DATA-1:0] i_req0_operand1,
  input  logic [NB_DATA-1:0] i_req0_operand2,
  input  logic [NB_OP-1:0]   i_req0_opcode,
  input  logic [4:0]         i_req0_shamt,
  input  logic               i_req1_valid,
  input  logic [NB_DATA-1:0] i_req1_operand1,
  input  logic [NB_DATA-1:0] i_req1_operand2,
  input  logic [NB_OP-1:0]   i_req1_opcode,
  input  logic [4:0]         i_req1_shamt,
  output logic               o_req0_ready,
  output logic               o_req1_ready,
  output logic [NB_DATA-1:0] o_alu_operand1,
  output logic [NB_DATA-1:0] o_alu_operand2,
  output logic [NB_OP-1:0]   o_alu_opcode,
  output logic [4:0]         o_alu_shamt,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_rsp0_valid,
  output logic               o_rsp1_valid,
  input  logic               i_rsp0_ready,
  input  logic               i_rsp1_ready,
  output logic [NB_DATA-1:0] o_rsp_result,
  output logic [15:0]        o_grant_cnt0,
  output logic [15:0]        o_grant_cnt1,
  output logic               o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t               r_state, w_next;
  logic                 r_rr, r_gnt;
  logic [NB_DATA-1:0]   r_op1, r_op2, r_result;
  logic [NB_OP-1:0]     r_opc;
  logic [4:0]           r_shamt;
  logic [15:0]          r_cnt0, r_cnt1;
  logic                 w_acc0, w_acc1, w_done;

  always_comb begin
    w_next = r_state;
    w_acc0 = 1'b0;
    w_acc1 = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        // rr only matters when both ask; a lone requester always wins
        if (i_req0_valid && (!i_req1_valid || !r_rr)) w_acc0 = 1'b1;
        else if (i_req1_valid)                        w_acc1 = 1'b1;
        if (w_acc0 || w_acc1) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        w_done = r_gnt ? i_rsp1_ready : i_rsp0_ready;
        if (w_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_rr     <= 1'b0;
      r_gnt    <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_opc    <= '0;
      r_shamt  <= '0;
      r_result <= '0;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc0) begin
        r_gnt   <= 1'b0;
        r_op1   <= i_req0_operand1;
        r_op2   <= i_req0_operand2;
        r_opc   <= i_req0_opcode;
        r_shamt <= i_req0_shamt;
      end else if (w_acc1) begin
        r_gnt   <= 1'b1;
        r_op1   <= i_req1_operand1;
        r_op2   <= i_req1_operand2;
        r_opc   <= i_req1_opcode;
        r_shamt <= i_req1_shamt;
      end
      if (r_state == S_EXEC) r_result <= i_alu_result;
      if (w_done) begin
        r_rr <= ~r_gnt;
        if (!r_gnt && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
        if ( r_gnt && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
      end
    end
  end

  // ALU sees the idle opcode only in IDLE; latched payload otherwise
  assign o_alu_operand1 = (r_state == S_IDLE) ? '0 : r_op1;
  assign o_alu_operand2 = (r_state == S_IDLE) ? '0 : r_op2;
  assign o_alu_opcode   = (r_state == S_IDLE) ? {NB_OP{1'b1}} : r_opc;
  assign o_alu_shamt    = (r_state == S_IDLE) ? 5'd0 : r_shamt;

  assign o_req0_ready = w_acc0;
  assign o_req1_ready = w_acc1;
  assign o_rsp0_valid = (r_state == S_RESP) && !r_gnt;
  assign o_rsp1_valid = (r_state == S_RESP) &&  r_gnt;
  assign o_rsp_result = r_result;
  assign o_grant_cnt0 = r_cnt0;
  assign o_grant_cnt1 = r_cnt1;
  assign o_busy       = (r_state != S_IDLE);

endmodule
